// File: rtl/display_pkg.sv
// Shared types and constants for the display character RAM controller.
// Optional feature macro: DISPLAY_RAM_SCROLL_EN (hardware scroll offset on the video port).
package display_pkg;

  // Clear-engine / port-A arbitration states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FILL = 2'd1,
    DONE = 2'd2
  } state_e;

  // ASCII space: power-up contents and clear value.
  localparam logic [7:0] FILL_CHAR_DEFAULT = 8'h20;

endpackage

// File: rtl/display_ram_ctrl_if.sv
// Bus bundle for the display RAM controller: CPU req/ack port, video fetch port, clear control.
// Optional feature macro: DISPLAY_RAM_SCROLL_EN adds the scroll_base input.
interface display_ram_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int DATA_W = 8
);

  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_ack;
  logic [DATA_W-1:0] cpu_rdata;
  logic              vid_re;
  logic [ADDR_W-1:0] vid_addr;
  logic [DATA_W-1:0] vid_rdata;
  logic              vid_valid;
  logic              clr_start;
  logic              clr_busy;
  logic              clr_done;
`ifdef DISPLAY_RAM_SCROLL_EN
  logic [ADDR_W-1:0] scroll_base;
`endif

  // Bus decoder / video generator side.
  modport master (
`ifdef DISPLAY_RAM_SCROLL_EN
    output scroll_base,
`endif
    output cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_re, vid_addr, clr_start,
    input  cpu_ack, cpu_rdata, vid_rdata, vid_valid, clr_busy, clr_done
  );

  // Controller side.
  modport slave (
`ifdef DISPLAY_RAM_SCROLL_EN
    input  scroll_base,
`endif
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata, vid_re, vid_addr, clr_start,
    output cpu_ack, cpu_rdata, vid_rdata, vid_valid, clr_busy, clr_done
  );

endinterface

// File: rtl/display_dpram.sv
// Generic inferred true dual-port RAM: port A read/write, port B read-only.
// Both ports are read-first and the array powers up holding INIT_VAL.
module display_dpram #(
  parameter int                 ADDR_W   = 10,
  parameter int                 DATA_W   = 8,
  parameter logic [DATA_W-1:0]  INIT_VAL = '0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              a_en,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_re,
  input  logic [ADDR_W-1:0] b_addr,
  output logic [DATA_W-1:0] b_rdata
);

  localparam int DEPTH = 2 ** ADDR_W;

  // NOTE: the array is initialised at configuration but has no reset; a reset
  // branch on a memory prevents RAM inference and turns it into flops.
  logic [DATA_W-1:0] mem [DEPTH] = '{default: INIT_VAL};
  logic [DATA_W-1:0] a_rdata_q;
  logic [DATA_W-1:0] b_rdata_q;

  // Port A write.
  always_ff @(posedge clk) begin
    if (a_en && a_we) begin
      mem[a_addr] <= a_wdata;
    end
  end

  // Port A registered read; returns the pre-write contents on a write.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      a_rdata_q <= '0;
    end else if (a_en) begin
      a_rdata_q <= mem[a_addr];
    end
  end

  // Port B registered read; holds its last value when not strobed.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      b_rdata_q <= '0;
    end else if (b_re) begin
      b_rdata_q <= mem[b_addr];
    end
  end

  assign a_rdata = a_rdata_q;
  assign b_rdata = b_rdata_q;

endmodule

// File: rtl/display_ram_ctrl.sv
// Display character RAM controller: CPU req/ack access and fill-with-FILL_CHAR clear engine
// share port A; port B is a never-stalled video fetch port.
// Optional feature macro: DISPLAY_RAM_SCROLL_EN adds (vid_addr + scroll_base) mod DEPTH addressing.
module display_ram_ctrl
  import display_pkg::*;
#(
  parameter int         ADDR_W    = 10,
  parameter int         DATA_W    = 8,
  parameter logic [7:0] FILL_CHAR = FILL_CHAR_DEFAULT
) (
  input logic              clk,
  input logic              reset_n,
  display_ram_ctrl_if.slave bus
);

  localparam logic [DATA_W-1:0] FILL_W = DATA_W'(FILL_CHAR);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] fill_cnt_q, fill_cnt_d;
  logic              ack_q, ack_d;
  logic              valid_q, valid_d;
  logic              cpu_go;
  logic              a_en, a_we;
  logic [ADDR_W-1:0] a_addr;
  logic [DATA_W-1:0] a_wdata;
  logic [DATA_W-1:0] a_rdata, b_rdata;
  logic [ADDR_W-1:0] vid_phys_addr;

  // Next state, fill counter and port-A mux. A request is not taken in its own ack
  // cycle, so a held cpu_req yields at most one access every two cycles.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_d    = state_q;
    fill_cnt_d = fill_cnt_q;
    cpu_go     = 1'b0;
    a_en       = 1'b0;
    a_we       = 1'b0;
    a_addr     = bus.cpu_addr;
    a_wdata    = bus.cpu_wdata;
    case (state_q)
      IDLE: begin
        if (bus.clr_start) begin
          state_d    = FILL;
          fill_cnt_d = '0;
        end else if (bus.cpu_req && !ack_q) begin
          cpu_go = 1'b1;
          a_en   = 1'b1;
          a_we   = bus.cpu_we;
        end
      end
      FILL: begin
        a_en       = 1'b1;
        a_we       = 1'b1;
        a_addr     = fill_cnt_q;
        a_wdata    = FILL_W;
        fill_cnt_d = fill_cnt_q + ADDR_W'(1);
        if (&fill_cnt_q) begin
          state_d = DONE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    ack_d   = cpu_go;
    valid_d = bus.vid_re;
  end

  // State, fill counter and ack/valid pipeline registers.
  always_ff @(posedge clk or negedge reset_n) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (!reset_n) begin
      state_q    <= IDLE;
      fill_cnt_q <= '0;
      ack_q      <= 1'b0;
      valid_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      fill_cnt_q <= fill_cnt_d;
      ack_q      <= ack_d;
      valid_q    <= valid_d;
    end
  end

`ifdef DISPLAY_RAM_SCROLL_EN
  // Scrolled video address; carry out is dropped so the window wraps.
  assign vid_phys_addr = bus.vid_addr + bus.scroll_base;
`else
  assign vid_phys_addr = bus.vid_addr;
`endif

  display_dpram #(
    .ADDR_W   (ADDR_W),
    .DATA_W   (DATA_W),
    .INIT_VAL (FILL_W)
  ) u_ram (
    .clk     (clk),
    .reset_n (reset_n),
    .a_en    (a_en),
    .a_we    (a_we),
    .a_addr  (a_addr),
    .a_wdata (a_wdata),
    .a_rdata (a_rdata),
    .b_re    (bus.vid_re),
    .b_addr  (vid_phys_addr),
    .b_rdata (b_rdata)
  );

  assign bus.cpu_ack   = ack_q;
  assign bus.cpu_rdata = a_rdata;
  assign bus.vid_valid = valid_q;
  assign bus.vid_rdata = b_rdata;
  assign bus.clr_busy  = (state_q != IDLE);
  assign bus.clr_done  = (state_q == DONE);

endmodule

// File: tb/tb_display_ram_ctrl.sv
// Directed self-checking bench for display_ram_ctrl (1Kx8, FILL_CHAR = 0x20).
// Builds with or without DISPLAY_RAM_SCROLL_EN.
module tb_display_ram_ctrl;
  import display_pkg::*;

  localparam int ADDR_W = 10;
  localparam int DATA_W = 8;
  localparam int DEPTH  = 1024;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  display_ram_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  display_ram_ctrl #(
    .ADDR_W    (ADDR_W),
    .DATA_W    (DATA_W),
    .FILL_CHAR (8'h20)
  ) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One CPU access followed by an idle cycle; lat = edges from request to ack.
  task automatic cpu_access(input logic we, input logic [ADDR_W-1:0] addr,
                            input logic [DATA_W-1:0] wd,
                            output logic [DATA_W-1:0] rd, output int lat);
    bus.cpu_req   = 1'b1;
    bus.cpu_we    = we;
    bus.cpu_addr  = addr;
    bus.cpu_wdata = wd;
    lat = 0;
    do begin
      tick();
      lat++;
    end while (!bus.cpu_ack && lat < 3000);
    rd = bus.cpu_rdata;
    bus.cpu_req = 1'b0;
    bus.cpu_we  = 1'b0;
    tick();
  endtask

  task automatic vid_read(input logic [ADDR_W-1:0] addr,
                          output logic [DATA_W-1:0] rd, output logic vld);
    bus.vid_re   = 1'b1;
    bus.vid_addr = addr;
    tick();
    rd  = bus.vid_rdata;
    vld = bus.vid_valid;
    bus.vid_re = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DATA_W-1:0] rd;
    logic              vld;
    int                lat, acks, edges, errs, ack_in_busy, done_seen;

    bus.cpu_req = 0; bus.cpu_we = 0; bus.cpu_addr = '0; bus.cpu_wdata = '0;
    bus.vid_re = 0; bus.vid_addr = '0; bus.clr_start = 0;
`ifdef DISPLAY_RAM_SCROLL_EN
    bus.scroll_base = '0;
`endif

    // Reset state
    repeat (2) tick();
    check("rst_cpu_ack",   bus.cpu_ack,   0);
    check("rst_cpu_rdata", bus.cpu_rdata, 0);
    check("rst_vid_rdata", bus.vid_rdata, 0);
    check("rst_vid_valid", bus.vid_valid, 0);
    check("rst_clr_busy",  bus.clr_busy,  0);
    check("rst_clr_done",  bus.clr_done,  0);
    reset_n = 1'b1;
    tick();

    // Power-up contents, latency 1
    cpu_access(1'b0, 10'h000, 8'h00, rd, lat);
    check("pwr_rd_000", rd, 8'h20);
    check("pwr_lat_000", lat, 1);
    cpu_access(1'b0, 10'h3FF, 8'h00, rd, lat);
    check("pwr_rd_3ff", rd, 8'h20);
    check("pwr_lat_3ff", lat, 1);

    // Held request: one ack every two cycles
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b0; bus.cpu_addr = 10'h3FF;
    acks = 0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if (bus.cpu_ack) acks++;
    end
    bus.cpu_req = 1'b0;
    tick();
    check("b2b_acks", acks, 2);

    // CPU write then video read
    cpu_access(1'b1, 10'h010, 8'h41, rd, lat);
    check("wr_lat", lat, 1);
    vid_read(10'h010, rd, vld);
    check("vid_rd_010", rd, 8'h41);
    check("vid_valid", vld, 1);
    tick();
    check("vid_valid_drop", bus.vid_valid, 0);
    check("vid_hold", bus.vid_rdata, 8'h41);

    // Same-address write and video read: video sees old data
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h020; bus.cpu_wdata = 8'h77;
    bus.vid_re = 1'b1; bus.vid_addr = 10'h020;
    tick();
    check("rf_ack", bus.cpu_ack, 1);
    check("rf_vid_old", bus.vid_rdata, 8'h20);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0; bus.vid_re = 1'b0;
    tick();
    vid_read(10'h020, rd, vld);
    check("rf_vid_new", rd, 8'h77);

    // Fill with 0x55, then clear
    for (int i = 0; i < DEPTH; i++) cpu_access(1'b1, ADDR_W'(i), 8'h55, rd, lat);
    cpu_access(1'b0, 10'h123, 8'h00, rd, lat);
    check("pre_clr_rd", rd, 8'h55);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("clr_busy_n1", bus.clr_busy, 1);
    check("clr_done_n1", bus.clr_done, 0);
    edges = 0;
    while (!bus.clr_done && edges < 2000) begin
      tick();
      edges++;
    end
    check("clr_done_time", edges, 1024);
    check("clr_busy_at_done", bus.clr_busy, 1);
    tick();
    check("clr_done_pulse", bus.clr_done, 0);
    check("clr_busy_end", bus.clr_busy, 0);
    errs = 0;
    for (int i = 0; i < DEPTH; i++) begin
      cpu_access(1'b0, ADDR_W'(i), 8'h00, rd, lat);
      if (rd !== 8'h20) errs++;
    end
    check("clr_all_20", errs, 0);

    // Clear and CPU write in the same cycle: clear wins, write deferred
    bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 10'h100; bus.cpu_wdata = 8'h99;
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    check("coll_no_ack", bus.cpu_ack, 0);
    check("coll_busy", bus.clr_busy, 1);
    edges = 1; ack_in_busy = 0; done_seen = 0;
    while (!bus.cpu_ack && edges < 3000) begin
      tick();
      edges++;
      if (bus.clr_done) done_seen++;
      if (bus.cpu_ack && bus.clr_busy) ack_in_busy++;
    end
    check("coll_ack_time", edges, 1027);
    check("coll_ack_in_busy", ack_in_busy, 0);
    check("coll_done_seen", done_seen, 1);
    bus.cpu_req = 1'b0; bus.cpu_we = 1'b0;
    tick();
    cpu_access(1'b0, 10'h100, 8'h00, rd, lat);
    check("coll_wdata_kept", rd, 8'h99);
    cpu_access(1'b0, 10'h101, 8'h00, rd, lat);
    check("coll_neighbour", rd, 8'h20);

    // Reset in the middle of a clear
    cpu_access(1'b1, 10'h000, 8'h55, rd, lat);
    cpu_access(1'b1, 10'h1FF, 8'h55, rd, lat);
    cpu_access(1'b1, 10'h200, 8'h55, rd, lat);
    cpu_access(1'b1, 10'h3FF, 8'h55, rd, lat);
    bus.clr_start = 1'b1;
    tick();
    bus.clr_start = 1'b0;
    done_seen = 0;
    for (int i = 0; i < 'h200; i++) begin
      tick();
      if (bus.clr_done) done_seen++;
    end
    reset_n = 1'b0;
    #1;
    check("mrst_busy",      bus.clr_busy,  0);
    check("mrst_cpu_rdata", bus.cpu_rdata, 0);
    check("mrst_vid_rdata", bus.vid_rdata, 0);
    check("mrst_ack",       bus.cpu_ack,   0);
    repeat (2) begin
      tick();
      if (bus.clr_done) done_seen++;
    end
    reset_n = 1'b1;
    repeat (3) begin
      tick();
      if (bus.clr_done) done_seen++;
    end
    check("mrst_no_done", done_seen, 0);
    check("mrst_idle", bus.clr_busy, 0);
    cpu_access(1'b0, 10'h000, 8'h00, rd, lat);
    check("mrst_000", rd, 8'h20);
    cpu_access(1'b0, 10'h1FF, 8'h00, rd, lat);
    check("mrst_1ff", rd, 8'h20);
    cpu_access(1'b0, 10'h200, 8'h00, rd, lat);
    check("mrst_200", rd, 8'h55);
    cpu_access(1'b0, 10'h3FF, 8'h00, rd, lat);
    check("mrst_3ff", rd, 8'h55);

    // Video addressing: scrolled with wrap, or direct
    cpu_access(1'b1, 10'h005, 8'h42, rd, lat);
`ifdef DISPLAY_RAM_SCROLL_EN
    bus.scroll_base = 10'h3FE;
    vid_read(10'h007, rd, vld);
    check("scroll_wrap", rd, 8'h42);
    vid_read(10'h3FF, rd, vld);
    check("scroll_3fd", rd, 8'h20);
`else
    vid_read(10'h005, rd, vld);
    check("vid_direct", rd, 8'h42);
`endif
    check("vid_valid_end", vld, 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
